siso_sched: RTL and testbench
=============================

# siso_sched

Round-robin scheduler that shares one external serial-in/serial-out shift chain (DEPTH flip-flop stages with common clock enable) between two requesters. Each request supplies a WIDTH-bit word. The block serializes the word LSB-first into the chain, flushes it through, and captures the WIDTH bits emerging at the chain output. It returns them to the requester with an ID tag. It sits between client logic and the SISO chain instance and is the only driver of the chain's input and enable.

## Interface
- WIDTH, 8: bits per transaction; ≥1.
- DEPTH, 6: number of stages in the attached chain; ≥1; must match the chain instance.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has a word.
- REQ0_DATA  in  WIDTH  requester 0 word.
- REQ0_READY  out  1  requester 0 word accepted this cycle.
- REQ1_VALID / REQ1_DATA / REQ1_READY: same as requester 0, for requester 1.
- RSP_VALID  out  1  response available.
- RSP_ID  out  1  requester index of the response.
- RSP_DATA  out  WIDTH  captured word, bit 0 = first bit out of chain.
- RSP_READY  in  1  response consumer accepts.
- SI  out  1  drives chain stage-0 D.
- CE  out  1  drives chain clock enable, all stages.
- SO  in  1  chain last-stage Q.

## Operation
- State machine states: IDLE, SHIFT, RESP.
- IDLE:
  - Arbitrate: if both VALID, grant the requester not granted last time; otherwise grant the single valid one.
  - REQn_READY = 1 combinationally for the granted requester only, only in IDLE.
  - On handshake: load DATA into the shift register, latch the ID, update the last-grant register, clear the counter, go to SHIFT.
- SHIFT:
  - CE = 1. SI = shift register bit 0.
  - Each cycle the shift register shifts right with 0 fill, and the counter k increments.
  - When DEPTH ≤ k ≤ DEPTH+WIDTH−1, SO is written into capture bit k−DEPTH.
  - On k = WIDTH+DEPTH−1, go to RESP; the counter is cleared.
- RESP:
  - RSP_VALID = 1. RSP_ID and RSP_DATA are stable.
  - On RSP_READY, go to IDLE.
  - No new request is accepted while in RESP.
- Counter width: clog2(WIDTH+DEPTH+1). There is no wrap inside a transaction.
- Stale chain contents never reach RSP_DATA, because capture starts only after DEPTH cycles of this transaction's shifting.
- CE = 0 outside SHIFT, so the chain holds its value.

## Timing
- Reset values:
  - state = IDLE; last-grant = 1, so requester 0 wins the first tie.
  - RSP_VALID = 0, RSP_ID = 0, RSP_DATA = 0, CE = 0, SI = 0.
  - REQn_READY = 0 unless REQn_VALID and granted in IDLE.
- Latency:
  - Accept in cycle t; SHIFT occupies cycles t+1 … t+WIDTH+DEPTH; RSP_VALID rises in cycle t+WIDTH+DEPTH+1.
  - Back-to-back throughput is one transaction per WIDTH+DEPTH+2 cycles when RSP_READY is tied high.
- RSP_READY sampled in the first RESP cycle completes the response; IDLE follows the next cycle.
- A VALID that drops before its handshake is not accepted; nothing is latched.
- RESET mid-SHIFT or mid-RESP:
  - Abort immediately; return to IDLE; the response is lost.
  - CE deasserts asynchronously, so the chain freezes with partial data; the next transaction flushes it.
- RSP_READY without RSP_VALID is ignored.

## Structure
- Package siso_sched_pkg holds:
  - the state enum (IDLE, SHIFT, RESP);
  - the counter-width constant function;
  - a request-ID type (1 bit).
- One sub-module: rr_arb2, a two-way round-robin arbiter with a last-grant register and grant-enable input, shared with other two-client blocks.
- The shift register, capture register and counter live in the top module.

## Test plan
- Reset, then REQ0_VALID=1, REQ0_DATA=8'hA5, with the chain model at DEPTH=6 → CE high for exactly 14 cycles; SI sequence 1,0,1,0,0,1,0,1,0…; RSP_VALID in cycle 15 after accept; RSP_ID=0; RSP_DATA=8'hA5.
- Both VALID continuously, data 8'h3C and 8'hC3, RSP_READY=1 → responses alternate 0,1,0,1 with matching data; the first grant goes to requester 0.
- RSP_READY held low 5 cycles in RESP → RSP_VALID and RSP_DATA stable; REQ0_READY and REQ1_READY stay 0; a new accept happens one cycle after RSP_READY.
- Chain preloaded with all ones, then request 8'h00 → RSP_DATA=8'h00, proving the flush.
- RESET asserted at SHIFT k=3 → CE and RSP_VALID drop immediately; the next request 8'h5A returns 8'h5A.
- WIDTH=1, DEPTH=1 build, request 1 → CE high 2 cycles; RSP_DATA=1.

Source files
------------

// File: rtl/siso_sched_pkg.sv
// Shared types and helpers for the SISO chain scheduler.
// State codes are plain constants so older tools that dislike enums can still read them.
package siso_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t RESP  = 2'd2;

   typedef logic reqId_t;

   // One extra count of headroom so the last shift index never wraps.
   function automatic int cntWidth(input int width, input int depth);
      return $clog2(width + depth + 1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the client not granted last time wins.
// Grants are only issued while en_i is high, and only an issued grant moves the history.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic lastGnt_q;
   logic lastGnt_d;

   // lastGnt_q holds the index of the most recent winner; reset favours client 0.
   always_comb begin
      gnt_o     = 2'b00;
      lastGnt_d = lastGnt_q;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = lastGnt_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
      if (gnt_o != 2'b00) begin
         lastGnt_d = gnt_o[1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lastGnt_q <= 1'b1;
      end else begin
         lastGnt_q <= lastGnt_d;
      end
   end

endmodule

// File: rtl/siso_sched.sv
// Shares one external serial-in/serial-out chain between two requesters:
// serialises a word LSB-first, flushes it through DEPTH stages and captures what emerges.
module siso_sched
   import siso_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   input  logic [WIDTH-1:0] req0_data_i,
   output logic             req0_ready_o,
   input  logic             req1_valid_i,
   input  logic [WIDTH-1:0] req1_data_i,
   output logic             req1_ready_o,
   output logic             rsp_valid_o,
   output logic             rsp_id_o,
   output logic [WIDTH-1:0] rsp_data_o,
   input  logic             rsp_ready_i,
   output logic             si_o,
   output logic             ce_o,
   input  logic             so_i
);

   localparam int             CW       = cntWidth(WIDTH, DEPTH);
   localparam logic [CW-1:0]  CapFirst = CW'(DEPTH);
   localparam logic [CW-1:0]  CapLast  = CW'(DEPTH + WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   reqId_t           id_q;
   reqId_t           id_d;
   logic [CW-1:0]    capIdx;
   logic [1:0]       gnt;
   logic             arbEn;

   assign arbEn = (state_q == IDLE);

   rr_arb2 uArb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (arbEn),
      .req_i ({req1_valid_i, req0_valid_i}),
      .gnt_o (gnt)
   );

   assign req0_ready_o = gnt[0];
   assign req1_ready_o = gnt[1];

   // Capture only once the chain has been fully refilled by this word, so stale
   // stage contents from an aborted transfer can never leak into the response.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      capIdx  = cnt_q - CapFirst;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               shift_d = gnt[1] ? req1_data_i : req0_data_i;
               id_d    = gnt[1];
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            for (int b = 0; b < WIDTH; b++) begin
               if ((cnt_q >= CapFirst) && (capIdx == CW'(b))) begin
                  cap_d[b] = so_i;
               end
            end
            if (cnt_q == CapLast) begin
               cnt_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
      end
   end

   // Chain controls decode straight from the state flop so reset freezes the chain at once.
   assign ce_o        = (state_q == SHIFT);
   assign si_o        = (state_q == SHIFT) & shift_q[0];
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_id_o    = id_q;
   assign rsp_data_o  = cap_q;

endmodule

// File: tb/tb_siso_sched.sv
// Bench for siso_sched: directed scenarios plus random traffic, all checked against
// a transaction-level model that treats the chain as a pure DEPTH-cycle delay.
module tb_siso_sched;

   localparam int W  = 8;
   localparam int D  = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0Valid = 1'b0;
   logic [W-1:0] req0Data = '0;
   logic         req0Ready;
   logic         req1Valid = 1'b0;
   logic [W-1:0] req1Data = '0;
   logic         req1Ready;
   logic         rspValid;
   logic         rspId;
   logic [W-1:0] rspData;
   logic         rspReady = 1'b1;
   logic         si;
   logic         ce;
   logic         so;
   logic [D-1:0] chain = '0;
   logic         preload = 1'b0;

   logic         sValid = 1'b0;
   logic [0:0]   sData = 1'b0;
   logic         sReady;
   logic         s1Valid = 1'b0;
   logic [0:0]   s1Data = 1'b0;
   logic         s1Ready;
   logic         sRspValid;
   logic         sRspId;
   logic [0:0]   sRspData;
   logic         sRspReady = 1'b1;
   logic         sSi;
   logic         sCe;
   logic         sChain = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   siso_sched #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (req0Valid),
      .req0_data_i  (req0Data),
      .req0_ready_o (req0Ready),
      .req1_valid_i (req1Valid),
      .req1_data_i  (req1Data),
      .req1_ready_o (req1Ready),
      .rsp_valid_o  (rspValid),
      .rsp_id_o     (rspId),
      .rsp_data_o   (rspData),
      .rsp_ready_i  (rspReady),
      .si_o         (si),
      .ce_o         (ce),
      .so_i         (so)
   );

   siso_sched #(.WIDTH(1), .DEPTH(1)) dutSmall (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (sValid),
      .req0_data_i  (sData),
      .req0_ready_o (sReady),
      .req1_valid_i (s1Valid),
      .req1_data_i  (s1Data),
      .req1_ready_o (s1Ready),
      .rsp_valid_o  (sRspValid),
      .rsp_id_o     (sRspId),
      .rsp_data_o   (sRspData),
      .rsp_ready_i  (sRspReady),
      .si_o         (sSi),
      .ce_o         (sCe),
      .so_i         (sChain)
   );

   // External chains: plain enabled shift registers with no reset, as in silicon.
   always @(posedge clk) begin
      if (preload) chain <= '1;
      else if (ce) chain <= {chain[D-2:0], si};
   end
   assign so = chain[D-1];

   always @(posedge clk) begin
      if (sCe) sChain <= sSi;
   end

   // Transaction model: a busy countdown of W+D shift cycles, then a pending response.
   int           mCeLeft = 0;
   logic         mPending = 1'b0;
   logic         mLast = 1'b1;
   logic         mId = 1'b0;
   logic [W-1:0] mWord = '0;
   logic         pick1;

   assign pick1 = req1Valid && (!req0Valid || !mLast);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mCeLeft  <= 0;
         mPending <= 1'b0;
         mLast    <= 1'b1;
      end else if (mCeLeft == 0 && !mPending) begin
         if (req0Valid || req1Valid) begin
            mId     <= pick1;
            mWord   <= pick1 ? req1Data : req0Data;
            mLast   <= pick1;
            mCeLeft <= W + D;
         end
      end else if (mCeLeft > 0) begin
         mCeLeft <= mCeLeft - 1;
         if (mCeLeft == 1) mPending <= 1'b1;
      end else if (rspReady) begin
         mPending <= 1'b0;
      end
   end

   logic mIdle;
   logic expG0;
   logic expG1;
   logic expSi;
   int   kIdx;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [W-1:0] d0,
                                input logic v1, input logic [W-1:0] d1, input logic rr);
      @(posedge clk);
      #2;
      req0Valid = v0;
      req0Data  = d0;
      req1Valid = v1;
      req1Data  = d1;
      rspReady  = rr;
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      sValid    = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic waitAccept(input int which);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if ((which == 0 && req0Ready) || (which == 1 && req1Ready) || (which == 2 && sReady))
            seen = 1'b1;
      end
      if (!seen) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitResponse(output logic id, output logic [W-1:0] data);
      bit seen;
      seen = 1'b0;
      id   = 1'b0;
      data = '0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (rspValid) begin
            seen = 1'b1;
            id   = rspId;
            data = rspData;
         end
      end
      if (!seen) checkOutput("response_timeout", 32'd0, 32'd1);
   endtask

   logic         gotId;
   logic [W-1:0] gotData;
   int           ceCnt;
   int           firstRsp;
   logic [8:0]   siSeq;

   initial begin
      rst     = 1'b1;
      preload = 1'b1;
      fork
         // Per-cycle comparison of every DUT output against the model.
         forever begin
            @(negedge clk);
            if (!rst) begin
               mIdle = (mCeLeft == 0) && !mPending;
               expG0 = mIdle && req0Valid && !pick1;
               expG1 = mIdle && pick1;
               kIdx  = W + D - mCeLeft;
               expSi = (mCeLeft > 0 && kIdx < W) ? mWord[kIdx] : 1'b0;
               checkOutput("ce", ce, mCeLeft > 0);
               checkOutput("si", si, expSi);
               checkOutput("rsp_valid", rspValid, mPending);
               checkOutput("req0_ready", req0Ready, expG0);
               checkOutput("req1_ready", req1Ready, expG1);
               if (mPending) begin
                  checkOutput("rsp_id", rspId, mId);
                  checkOutput("rsp_data", rspData, mWord);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #2;
      rst     = 1'b0;
      preload = 1'b0;
      #1;
      checkOutput("reset_rsp_valid", rspValid, 0);
      checkOutput("reset_rsp_id", rspId, 0);
      checkOutput("reset_rsp_data", rspData, 0);
      checkOutput("reset_ce", ce, 0);
      checkOutput("reset_si", si, 0);

      $display("[TB] single request 8'hA5");
      applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      waitAccept(0);
      @(posedge clk);
      #2 req0Valid = 1'b0;
      ceCnt = 0; firstRsp = 0; siSeq = '0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (ce) ceCnt++;
         if (i <= 9) siSeq[i-1] = si;
         if (rspValid && firstRsp == 0) begin
            firstRsp = i;
            gotId    = rspId;
            gotData  = rspData;
         end
      end
      checkOutput("a5_ce_cycles", ceCnt, 14);
      checkOutput("a5_latency", firstRsp, 15);
      checkOutput("a5_si_seq", siSeq, 9'h0A5);
      checkOutput("a5_id", gotId, 0);
      checkOutput("a5_data", gotData, 8'hA5);

      $display("[TB] alternating requesters");
      doReset();
      applyStimulus(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1);
      for (int n = 0; n < 4; n++) begin
         waitResponse(gotId, gotData);
         checkOutput("rr_id", gotId, n % 2);
         checkOutput("rr_data", gotData, (n % 2) ? 8'hC3 : 8'h3C);
         @(posedge clk);
      end

      $display("[TB] response backpressure");
      doReset();
      applyStimulus(1'b1, 8'h77, 1'b1, 8'h11, 1'b0);
      waitResponse(gotId, gotData);
      checkOutput("bp_id", gotId, 0);
      checkOutput("bp_data", gotData, 8'h77);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_valid", rspValid, 1);
         checkOutput("bp_hold_data", rspData, 8'h77);
         checkOutput("bp_hold_ready", {req1Ready, req0Ready}, 2'b00);
      end
      @(posedge clk);
      #2 rspReady = 1'b1;
      @(negedge clk);
      checkOutput("bp_last_valid", rspValid, 1);
      @(negedge clk);
      checkOutput("bp_next_accept", req1Ready, 1);
      @(posedge clk);
      #2;
      req0Valid = 1'b0;
      req1Valid = 1'b0;

      $display("[TB] flush of preloaded ones");
      doReset();
      @(posedge clk);
      #2 preload = 1'b1;
      @(posedge clk);
      #2 preload = 1'b0;
      applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      waitAccept(0);
      @(posedge clk);
      #2 req0Valid = 1'b0;
      waitResponse(gotId, gotData);
      checkOutput("flush_data", gotData, 8'h00);
      @(posedge clk);

      $display("[TB] reset during shift");
      doReset();
      applyStimulus(1'b1, 8'hF0, 1'b0, 8'h00, 1'b1);
      waitAccept(0);
      @(posedge clk);
      #2 req0Valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("abort_ce_before", ce, 1);
      rst = 1'b1;
      #1;
      checkOutput("abort_ce", ce, 0);
      checkOutput("abort_rsp_valid", rspValid, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      waitAccept(0);
      @(posedge clk);
      #2 req0Valid = 1'b0;
      waitResponse(gotId, gotData);
      checkOutput("abort_next_data", gotData, 8'h5A);
      @(posedge clk);

      $display("[TB] WIDTH=1 DEPTH=1 instance");
      @(posedge clk);
      #2;
      sValid = 1'b1;
      sData  = 1'b1;
      waitAccept(2);
      @(posedge clk);
      #2 sValid = 1'b0;
      ceCnt = 0; firstRsp = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (sCe) ceCnt++;
         if (sRspValid && firstRsp == 0) begin
            firstRsp = i;
            checkOutput("small_data", sRspData, 1);
            checkOutput("small_id", sRspId, 0);
         end
      end
      checkOutput("small_ce_cycles", ceCnt, 2);
      checkOutput("small_latency", firstRsp, 3);
      checkOutput("small_req1_ready", s1Ready, 0);

      $display("[TB] random traffic");
      doReset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         rst       = ($urandom_range(0, 599) == 0);
         req0Valid = ($urandom_range(0, 3) != 0);
         req1Valid = ($urandom_range(0, 3) != 0);
         req0Data  = W'($urandom);
         req1Data  = W'($urandom);
         rspReady  = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #2;
      rst       = 1'b0;
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      rspReady  = 1'b1;
      repeat (40) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
